// File: rtl/gpio_pin_sampler.sv
// GPIO input sampler: 2-flop sync, level filter (debounce under GPIO_DEBOUNCE_EN), sticky edge status, read port, irq.
// Pin edge to status in 3 cycles (3+DB_CYCLES with debounce); reads answered 1 cycle later, 1 per cycle, no stall.
module gpio_pin_sampler #(
   parameter int WIDTH     = 8,
   parameter int DB_CYCLES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] pin_in,
   input  logic [WIDTH-1:0] rx_en,
   input  logic [WIDTH-1:0] rise_mask,
   input  logic [WIDTH-1:0] fall_mask,
   input  logic             rd_req,
   input  logic             rd_sel,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             irq
);

   if (DB_CYCLES < 2 || DB_CYCLES > 255) begin : g_bad_db
      $error("gpio_pin_sampler: DB_CYCLES must be in 2..255");
   end

   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] lvl;
   logic [WIDTH-1:0] armed;
   logic [WIDTH-1:0] status;
   logic [1:0]       warm;
   logic [WIDTH-1:0] upd;
   logic [WIDTH-1:0] lvl_nxt;
   logic [WIDTH-1:0] ev;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rd_view;

`ifdef GPIO_DEBOUNCE_EN
   logic [7:0] db_cnt [WIDTH];

   // A pin flips only after it has disagreed with lvl for DB_CYCLES straight cycles.
   always_comb begin
      upd = '0;
      for (int i = 0; i < WIDTH; i++) begin
         upd[i] = (sync[i] != lvl[i]) && (db_cnt[i] == 8'(DB_CYCLES));
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < WIDTH; i++) begin
         if (!reset || sync[i] == lvl[i] || upd[i]) begin
            db_cnt[i] <= 8'd0;
         end else if (db_cnt[i] != 8'hff) begin
            db_cnt[i] <= db_cnt[i] + 8'd1;
         end
      end
   end
`else
   assign upd = sync ^ lvl;
`endif

   // warm[1] marks that sync now holds real pad samples rather than reset zeros.
   assign lvl_nxt = lvl ^ (upd & {WIDTH{warm[1]}});

   // The first lvl load after reset is silent until the pin has been armed.
   assign ev = ((lvl_nxt & ~lvl & rise_mask) | (~lvl_nxt & lvl & fall_mask)) & rx_en & armed;

   assign clr     = (rd_req && rd_sel) ? status : '0;
   assign rd_view = rd_sel ? status : (lvl & rx_en);

   always_ff @(posedge clock) begin
      if (!reset) begin
         meta     <= '0;
         sync     <= '0;
         warm     <= 2'b00;
         lvl      <= '0;
         armed    <= '0;
         status   <= '0;
         irq      <= 1'b0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else begin
         meta     <= pin_in;
         sync     <= meta;
         warm     <= {warm[0], 1'b1};
         lvl      <= lvl_nxt;
         armed    <= armed | ({WIDTH{warm[1]}} & (~(sync ^ lvl) | upd));
         // A new event outranks the read-clear on the same bit.
         status   <= (status & ~clr) | ev;
         irq      <= |status;
         rd_valid <= rd_req;
         if (rd_req) begin
            rd_data <= rd_view;
         end
      end
   end

endmodule

// File: tb/tb_gpio_pin_sampler.sv
// Bench for gpio_pin_sampler: directed scenarios plus randomized traffic against a sample-history reference model.
module tb_gpio_pin_sampler;
   localparam int W = 8;

   logic         clock = 1'b0;
   logic         reset;
   logic [W-1:0] pin_in, rx_en, rise_mask, fall_mask;
   logic         rd_req, rd_sel;
   logic [W-1:0] rd_data;
   logic         rd_valid, irq;

   int vectors = 0;
   int miscompares = 0;
   bit mon_on = 1'b0;

   gpio_pin_sampler #(.WIDTH(W), .DB_CYCLES(4)) dut (
      .clock(clock), .reset(reset), .pin_in(pin_in), .rx_en(rx_en),
      .rise_mask(rise_mask), .fall_mask(fall_mask), .rd_req(rd_req),
      .rd_sel(rd_sel), .rd_data(rd_data), .rd_valid(rd_valid), .irq(irq)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model: pin samples since reset; lvl is the sample taken two edges back,
   // the first load is silent, events are lvl transitions gated by masks and rx_en.
   logic [W-1:0] hist[$];
   int           n_edges = 0;
   logic [W-1:0] m_lvl = '0, m_stat = '0, m_new, m_ev, e_dat = '0;
   logic         e_vld = 1'b0, e_irq = 1'b0;

   always @(posedge clock) begin
      if (!reset) begin
         hist.delete();
         n_edges = 0;
         m_lvl   = '0;
         m_stat  = '0;
         e_vld   = 1'b0;
         e_dat   = '0;
         e_irq   = 1'b0;
      end else begin
         hist.push_front(pin_in);
         if (hist.size() > 3) void'(hist.pop_back());
         if (n_edges < 10) n_edges++;
         m_new = (n_edges >= 3) ? hist[2] : '0;
         m_ev  = (n_edges >= 4) ? (((m_new & ~m_lvl & rise_mask) | (~m_new & m_lvl & fall_mask)) & rx_en) : '0;
         e_irq = (m_stat != '0);
         e_vld = rd_req;
         if (rd_req) e_dat = rd_sel ? m_stat : (m_lvl & rx_en);
         if (rd_req && rd_sel) m_stat = '0;
         m_stat = m_stat | m_ev;
         m_lvl  = m_new;
      end
   end

   always @(negedge clock) begin
      if (mon_on) begin
         chk("mdl_vld", rd_valid, e_vld);
         if (e_vld) chk("mdl_data", rd_data, e_dat);
         chk("mdl_irq", irq, e_irq);
      end
   end

   initial begin
      reset = 1'b0; rd_req = 1'b1; rd_sel = 1'b1;
      pin_in = '0; rx_en = '1; rise_mask = 8'h01; fall_mask = '0;
      tick(); tick();
      @(negedge clock);
      chk("rst_vld", rd_valid, 0);
      chk("rst_irq", irq, 0);
      chk("rst_data", rd_data, 0);
      tick();
      reset = 1'b1; rd_req = 1'b0;
`ifndef GPIO_DEBOUNCE_EN
      mon_on = 1'b1;
`endif
      repeat (5) tick();

`ifdef GPIO_DEBOUNCE_EN
      rise_mask = 8'h04; fall_mask = 8'h04;
      pin_in = 8'h04; repeat (3) tick();
      pin_in = 8'h00; repeat (12) tick();
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      @(negedge clock);
      chk("glitch_stat", rd_data, 8'h00);
      pin_in = 8'h04; repeat (6) tick();
      pin_in = 8'h00; repeat (3) tick();
      rd_req = 1'b1; tick(); rd_req = 1'b0;
      @(negedge clock);
      chk("pulse_rise", rd_data, 8'h04);
      repeat (8) tick();
      rd_req = 1'b1; tick();
      @(negedge clock);
      chk("pulse_fall", rd_data, 8'h04);
      tick(); rd_req = 1'b0;
      @(negedge clock);
      chk("pulse_once", rd_data, 8'h00);
      chk("pulse_irq", irq, 0);
`else
      // Single rise on pin 0: status lands on the 3rd edge, irq on the 4th.
      pin_in = 8'h01;
      tick(); tick();
      rd_req = 1'b1; rd_sel = 1'b1;
      tick();
      @(negedge clock);
      chk("r29_vld", rd_valid, 1);
      chk("r29_early", rd_data, 8'h00);
      chk("r29_irq0", irq, 0);
      tick(); rd_req = 1'b0;
      @(negedge clock);
      chk("r29_stat", rd_data, 8'h01);
      chk("r29_irq1", irq, 1);
      tick();
      @(negedge clock);
      chk("r29_vld_end", rd_valid, 0);
      chk("r29_irq_clr", irq, 0);

      // Read collides with a fresh event on the same bit; set wins.
      pin_in = 8'h00; repeat (4) tick();
      pin_in = 8'h01; tick();
      pin_in = 8'h00; tick();
      pin_in = 8'h01; tick(); tick();
      rd_req = 1'b1; rd_sel = 1'b1;
      tick();
      @(negedge clock);
      chk("r30_rd1", rd_data, 8'h01);
      tick();
      @(negedge clock);
      chk("r30_rd2", rd_data, 8'h01);
      chk("r30_vld2", rd_valid, 1);
      chk("r30_irq", irq, 1);
      tick(); rd_req = 1'b0;
      @(negedge clock);
      chk("r30_rd3", rd_data, 8'h00);
      chk("r30_vld3", rd_valid, 1);
      chk("r30_irq_clr", irq, 0);

      // Receive disabled everywhere: nothing visible, nothing latched.
      rx_en = '0; rise_mask = '1; fall_mask = '1;
      for (int i = 0; i < 20; i++) begin
         pin_in = W'($urandom);
         rd_req = 1'b1; rd_sel = i[0];
         tick();
         @(negedge clock);
         chk("r31_data", rd_data, 8'h00);
         chk("r31_irq", irq, 0);
      end
      rd_req = 1'b0;

      for (int i = 0; i < 400; i++) begin
         pin_in = W'($urandom);
         if ($urandom_range(0, 7) == 0) begin
            rx_en     = W'($urandom) | W'($urandom);
            rise_mask = W'($urandom);
            fall_mask = W'($urandom);
         end
         rd_req = 1'($urandom);
         rd_sel = 1'($urandom);
         tick();
      end
`endif

      // Back-to-back level reads, then reset mid-stream.
      rx_en = '1; pin_in = 8'hA5; rd_req = 1'b0; rd_sel = 1'b0;
      repeat (4) tick();
      rd_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clock);
         chk("b2b_vld", rd_valid, 1);
         chk("b2b_data", rd_data, 8'hA5);
      end
      reset = 1'b0;
      tick();
      @(negedge clock);
      chk("mid_rst_vld", rd_valid, 0);
      chk("mid_rst_data", rd_data, 8'h00);
      chk("mid_rst_irq", irq, 0);
      reset = 1'b1;
      tick();
      @(negedge clock);
      chk("post_rst_vld", rd_valid, 1);
      chk("post_rst_data", rd_data, 8'h00);
      rd_req = 1'b0;
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gpio_pin_sampler.md
GPIO_PIN_SAMPLER -- requirements
Module: gpio_pin_sampler

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of GPIO pins.
REQ-002 The block SHALL have parameter DB_CYCLES, default 4, giving the debounce stability count (range 2..255).
REQ-003 The block SHALL have port clock, input, 1 bit, the rising-edge clock.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port pin_in, input, WIDTH bits: raw asynchronous pad inputs.
REQ-006 The block SHALL have port rx_en, input, WIDTH bits: per-pin receive enable (1 = pin is an input).
REQ-007 The block SHALL have port rise_mask, input, WIDTH bits: per-pin enable for rising-edge events.
REQ-008 The block SHALL have port fall_mask, input, WIDTH bits: per-pin enable for falling-edge events.
REQ-009 The block SHALL have port rd_req, input, 1 bit: read strobe, one cycle.
REQ-010 The block SHALL have port rd_sel, input, 1 bit: 0 selects the pin level, 1 selects the event status.
REQ-011 The block SHALL have port rd_data, output, WIDTH bits: read data.
REQ-012 The block SHALL have port rd_valid, output, 1 bit: rd_data qualifier, high for one cycle.
REQ-013 The block SHALL have port irq, output, 1 bit: high while any status bit is set.

Function
REQ-014 Each pin SHALL pass through a 2-flop synchronizer; the synchronized value is sync[i].
REQ-015 Each pin SHALL have a filtered level lvl[i] that updates from sync[i] per REQ-027/028.
REQ-016 A rising event on pin i SHALL be detected when lvl[i] goes 0->1 with rx_en[i]=1 and rise_mask[i]=1; a falling event is the 1->0 equivalent gated by fall_mask[i].
REQ-017 A detected event SHALL set sticky status[i] on the next clock edge.
REQ-018 Pins with rx_en[i]=0 SHALL read 0 in the level view, SHALL NOT set status, and SHALL keep any status already set.
REQ-019 rd_req SHALL be answered exactly 1 cycle later: rd_valid=1 for one cycle, rd_data = the level or status view selected by rd_sel as sampled at rd_req.
REQ-020 A status read (rd_sel=1) SHALL return the status word and clear the bits returned, in the same cycle rd_valid is asserted.
REQ-021 Simultaneous event and clear on the same bit: set SHALL win, so the bit remains 1 after the read.
REQ-022 A rd_req asserted while rd_valid is high SHALL be accepted, giving back-to-back responses (throughput 1 read/cycle).
REQ-023 irq SHALL be the registered OR of status, asserted 1 cycle after the status bit sets.
REQ-024 Total latency from a pin edge to the status bit SHALL be 3 cycles without debounce, and 3+DB_CYCLES cycles with debounce.

Reset
REQ-025 While reset=0 at a clock edge, the block SHALL set the synchronizers, lvl, status, rd_data, rd_valid and irq to 0, and SHALL clear the debounce counters.
REQ-026 A rd_req coinciding with reset SHALL be discarded, with no rd_valid afterwards; the lvl 0 value after reset SHALL NOT generate a rising event until the pin is observed low then high, or high for one filter period after reset (no event from the reset value itself: the first update after reset loads lvl silently).

Configuration
REQ-027 With macro GPIO_DEBOUNCE_EN defined, each pin SHALL have an 8-bit counter; lvl[i] SHALL take sync[i] only after sync[i] differs from lvl[i] for DB_CYCLES consecutive cycles, and any return to equality SHALL reset the counter to 0.
REQ-028 Without GPIO_DEBOUNCE_EN, lvl[i] SHALL equal sync[i] delayed by one register, with no counters instantiated; DB_CYCLES SHALL be ignored.

Verification
REQ-029 Reset, then pin_in[0] 0->1 with rx_en=0xFF, rise_mask=0x01, no debounce -> status[0]=1 at cycle 3, irq=1 at cycle 4.
REQ-030 Status read (rd_sel=1) in the same cycle as a new event on pin 0 -> rd_data=0x01 and status[0] is still 1 afterwards; a second read returns 0x01 and then status=0, irq=0.
REQ-031 rx_en=0x00 with all pins toggling -> the level read returns 0x00, status stays 0x00, irq stays 0.
REQ-032 GPIO_DEBOUNCE_EN with DB_CYCLES=4: a 3-cycle glitch on pin 2 -> no event; a 6-cycle pulse -> exactly one rise event (with fall_mask=0x04, also a fall event).
REQ-033 Back-to-back rd_req for 3 cycles -> 3 consecutive rd_valid pulses with matching data; reset asserted mid-stream -> rd_valid=0 on the next cycle and all outputs 0.
